// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width, busy-wait
// default and the scheduler state encoding.
package uart_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned BUSY_WAIT_DEF = 16;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STROBE    = 2'd1,
    WAIT_RISE = 2'd2,
    WAIT_FALL = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping
// modulo N. Purely combinational so it can sit in front of any bus arbiter.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr) + i) % N);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte
// producers; one byte per grant, then follows the tx_busy rise/fall handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned BUSY_WAIT = BUSY_WAIT_DEF,
  localparam int unsigned IDX_W    = $clog2(NREQ),
  localparam int unsigned CNT_W    = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [BYTE_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [BYTE_W-1:0]        tx_data,
  output logic                     tx_wr,
  input  logic                     tx_busy,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     idle,
  output logic                     timeout
);

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  win;
  logic              win_any;
  logic [CNT_W-1:0]  cnt;
  byte_t             sel_byte;

  rr_pick #(
    .N  (NREQ),
    .IW (IDX_W)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .winner (win),
    .any    (win_any)
  );

  // Byte of the current winner.
  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDX_W'(i)) sel_byte = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  assign idle = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      req_ready <= '0;
      tx_data   <= '0;
      tx_wr     <= 1'b0;
      grant_id  <= '0;
      timeout   <= 1'b0;
    end else begin
      req_ready <= '0;
      tx_wr     <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (!tx_busy && win_any) begin
            tx_data   <= sel_byte;
            req_ready <= NREQ'(1) << win;
            grant_id  <= win;
            rr_ptr    <= (win == IDX_W'(NREQ - 1)) ? '0 : win + IDX_W'(1);
            state     <= STROBE;
          end
        end
        STROBE: begin
          tx_wr <= 1'b1;
          cnt   <= '0;
          state <= WAIT_RISE;
        end
        WAIT_RISE: begin
          // Give up if the uart never acknowledges the write.
          if (tx_busy) begin
            state <= WAIT_FALL;
          end else if (cnt == CNT_W'(BUSY_WAIT - 1)) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_FALL: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart busy model and a
// requester data-hold checker.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        idle;
  logic        timeout;

  logic        force_busy = 1'b0;
  logic        model_busy = 1'b0;
  logic        model_en = 1'b1;
  int          rise_cnt = 0;
  int          busy_cnt = 0;

  int          errors = 0;
  int          checks = 0;

  logic [7:0]  wr_log[$];
  logic [1:0]  gid_log[$];

  logic [3:0]  hold_v = '0;
  logic [7:0]  hold_d [4];

  assign tx_busy = force_busy | model_busy;

  uart_tx_arbiter #(
    .NREQ      (4),
    .BUSY_WAIT (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .idle      (idle),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Uart model: busy rises 2 cycles after tx_wr and stays high 10 cycles.
  always @(negedge clk) begin
    if (tx_wr) begin
      rise_cnt = 2;
    end else if (rise_cnt > 0) begin
      rise_cnt--;
      if (rise_cnt == 0 && model_en) begin
        model_busy = 1'b1;
        busy_cnt   = 10;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) model_busy = 1'b0;
    end
    if (tx_wr) wr_log.push_back(tx_data);
    if (|req_ready) gid_log.push_back(grant_id);
  end

  // A pending, unacknowledged byte must not change.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (hold_v[i] && req_valid[i] && !req_ready[i])
        check($sformatf("hold%0d", i), 32'(req_data[i*8 +: 8]), 32'(hold_d[i]));
      hold_v[i] <= req_valid[i] && !req_ready[i];
      hold_d[i] <= req_data[i*8 +: 8];
    end
  end

  // One cycle, sampled just after the falling edge; acked requesters withdraw.
  task automatic step();
    @(negedge clk);
    #1;
    req_valid = req_valid & ~req_ready;
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data[i*8 +: 8] = b;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic wait_idle(input int max);
    bit seen = 0;
    for (int k = 0; k < max && !seen; k++) begin
      step();
      if (idle) seen = 1;
    end
    check("idle_wait", 32'(seen), 32'd1);
  endtask

  task automatic wait_wr(input int max, output logic [7:0] d);
    bit seen = 0;
    d = '0;
    for (int k = 0; k < max && !seen; k++) begin
      step();
      if (tx_wr) begin
        seen = 1;
        d    = tx_data;
      end
    end
    check("wr_wait", 32'(seen), 32'd1);
  endtask

  task automatic wait_ready(input int max);
    bit seen = 0;
    for (int k = 0; k < max && !seen; k++) begin
      step();
      if (|req_ready) seen = 1;
    end
    check("ready_wait", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] exp_b [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [1:0] exp_g [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int wb, gb, n0;
    bit rearmed;

    // Reset held with every requester valid.
    req_valid = 4'hF;
    req_data  = 32'h4433_2211;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_wr", 32'(tx_wr), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_data", 32'(tx_data), 32'h00);
    end
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    req_valid = '0;
    req_data  = '0;
    reset     = 1'b1;
    step();
    check("rst_no_wr", 32'(wr_log.size()), 32'd0);

    // Single byte from requester 2.
    set_byte(2, 8'hA5);
    req_valid = 4'b0100;
    step();
    check("single_ready", 32'(req_ready), 32'b0100);
    check("single_data", 32'(tx_data), 32'hA5);
    check("single_gid", 32'(grant_id), 32'd2);
    check("single_busy_state", 32'(idle), 32'd0);
    step();
    check("single_wr", 32'(tx_wr), 32'd1);
    check("single_ready_off", 32'(req_ready), 32'd0);
    wait_idle(60);
    check("single_wr_count", 32'(wr_log.size()), 32'd1);
    check("single_wr_byte", 32'(wr_log[0]), 32'hA5);

    // Round robin from pointer 0; requesters 0 and 1 re-arm after 22 is taken.
    do_reset();
    wb = wr_log.size();
    gb = gid_log.size();
    req_data  = 32'h4433_2211;
    req_valid = 4'hF;
    rearmed   = 0;
    for (int k = 0; k < 300 && (wr_log.size() - wb) < 6; k++) begin
      step();
      if (req_ready[1] && !rearmed) begin
        set_byte(0, 8'h55);
        set_byte(1, 8'h66);
        req_valid = req_valid | 4'b0011;
        rearmed   = 1;
      end
    end
    wait_idle(60);
    check("rr_count", 32'(wr_log.size() - wb), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (wb + k < wr_log.size())
        check($sformatf("rr_byte%0d", k), 32'(wr_log[wb+k]), 32'(exp_b[k]));
      if (gb + k < gid_log.size())
        check($sformatf("rr_gid%0d", k), 32'(gid_log[gb+k]), 32'(exp_g[k]));
    end

    // Busy gating in IDLE.
    force_busy = 1'b1;
    set_byte(0, 8'h77);
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      check("gate_ready", 32'(req_ready), 32'd0);
      check("gate_idle", 32'(idle), 32'd1);
    end
    force_busy = 1'b0;
    step();
    check("gate_grant", 32'(req_ready), 32'b0001);
    check("gate_data", 32'(tx_data), 32'h77);
    check("gate_gid", 32'(grant_id), 32'd0);
    wait_idle(60);

    // Timeout: uart never raises busy; requester 2 follows.
    model_en = 1'b0;
    set_byte(1, 8'h88);
    set_byte(2, 8'h99);
    req_valid = 4'b0110;
    wait_wr(20, d);
    check("to_wr_byte", 32'(d), 32'h88);
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 15) check("to_early", 32'(timeout), 32'd0);
      if (k == 16) begin
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_idle", 32'(idle), 32'd1);
      end
      if (k == 17) begin
        check("to_pulse_end", 32'(timeout), 32'd0);
        check("to_next_ready", 32'(req_ready), 32'b0100);
        check("to_next_data", 32'(tx_data), 32'h99);
        model_en = 1'b1;
      end
    end
    wait_idle(60);

    // Reset during WAIT_FALL clears the pointer; no spurious write afterwards.
    set_byte(2, 8'h5A);
    req_valid = 4'b0100;
    wait_wr(20, d);
    check("mid_wr_byte", 32'(d), 32'h5A);
    for (int k = 0; k < 3; k++) step();
    check("mid_in_fall", 32'(idle), 32'd0);
    reset = 1'b0;
    step();
    check("mid_idle", 32'(idle), 32'd1);
    check("mid_wr", 32'(tx_wr), 32'd0);
    check("mid_data", 32'(tx_data), 32'h00);
    check("mid_gid", 32'(grant_id), 32'd0);
    reset = 1'b1;
    n0 = wr_log.size();
    set_byte(1, 8'hB1);
    set_byte(3, 8'hB3);
    req_valid = 4'b1010;
    wait_ready(40);
    check("mid_no_spurious", 32'(wr_log.size()), 32'(n0));
    check("mid_ptr_ready", 32'(req_ready), 32'b0010);
    check("mid_ptr_gid", 32'(grant_id), 32'd1);
    check("mid_ptr_data", 32'(tx_data), 32'hB1);
    wait_idle(60);
    wait_ready(40);
    check("mid_next_gid", 32'(grant_id), 32'd3);
    check("mid_next_data", 32'(tx_data), 32'hB3);
    wait_idle(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
